// File: rtl/clock_set_ctrl.sv
// Push-button sequencer for the clock/calendar datapath: synchronises MODE/ADV,
// walks the set states, and issues advance pulses with auto-repeat, timeout and blink.
module clock_set_ctrl #(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int TIMEOUT      = 64,
  parameter int BLINK_HALF   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       adv_btn,
  output logic       timeset,
  output logic       alarmset,
  output logic       hrsadv,
  output logic       minadv,
  output logic       dayadv,
  output logic       dateadv,
  output logic       monthadv,
  output logic       alarmon,
  output logic [2:0] field,
  output logic       blink
);

  // state     | meaning
  // RUN       | normal timekeeping, ADV toggles alarm enable
  // SET_HRS   | edit time hours
  // SET_MIN   | edit time minutes
  // SET_DAY   | edit day of week
  // SET_MONTH | edit month
  // SET_DATE  | edit date
  // ALM_HRS   | edit alarm hours
  // ALM_MIN   | edit alarm minutes
  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HRS   = 3'd1,
    SET_MIN   = 3'd2,
    SET_DAY   = 3'd3,
    SET_MONTH = 3'd4,
    SET_DATE  = 3'd5,
    ALM_HRS   = 3'd6,
    ALM_MIN   = 3'd7
  } state_t;

  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [HW-1:0] HOLD_FIRE   = HW'(REPEAT_DELAY);
  // Reloading below the fire value spaces later pulses REPEAT_RATE apart.
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE + 1);
  localparam logic [IW-1:0] IDLE_MAX    = IW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_HALF - 1);

  state_t        state, state_nxt;
  logic [2:0]    mode_sync, adv_sync;
  logic [HW-1:0] hold, hold_nxt;
  logic [IW-1:0] idle, idle_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          rep_en, rep_en_nxt;
  logic          blink_nxt, alarmon_nxt, timeset_nxt, alarmset_nxt;
  logic          hrs_nxt, min_nxt, day_nxt, date_nxt, month_nxt;
  logic          adv_fire, mode_ev, adv_ev, adv_s2, in_set;

  assign mode_ev = mode_sync[1] & ~mode_sync[2];
  assign adv_ev  = adv_sync[1] & ~adv_sync[2];
  assign adv_s2  = adv_sync[1];
  assign in_set  = (state != RUN);
  assign field   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    alarmon_nxt = alarmon;
    adv_fire    = 1'b0;
    rep_en_nxt  = rep_en;
    hold_nxt    = hold;
    idle_nxt    = idle;
    blink_nxt   = blink;
    bcnt_nxt    = bcnt;

    // MODE has priority; a coincident ADV press is dropped and repeat disarmed.
    if (mode_ev) begin
      state_nxt  = state_t'(state + 3'd1);
      rep_en_nxt = 1'b0;
      hold_nxt   = '0;
    end else if (adv_ev) begin
      if (in_set) begin
        adv_fire   = 1'b1;
        rep_en_nxt = 1'b1;
        hold_nxt   = HW'(1);
      end else begin
        alarmon_nxt = ~alarmon;
      end
    end else if (rep_en && adv_s2) begin
      if (hold == HOLD_FIRE) begin
        adv_fire = 1'b1;
        hold_nxt = HOLD_RELOAD;
      end else begin
        hold_nxt = hold + HW'(1);
      end
    end else begin
      rep_en_nxt = 1'b0;
      hold_nxt   = '0;
    end

    if (mode_ev || adv_ev || !in_set) begin
      idle_nxt = '0;
    end else if (idle == IDLE_MAX) begin
      state_nxt  = RUN;
      idle_nxt   = '0;
      adv_fire   = 1'b0;
      rep_en_nxt = 1'b0;
      hold_nxt   = '0;
    end else begin
      idle_nxt = idle + IW'(1);
    end

    if (state_nxt == RUN) begin
      blink_nxt = 1'b0;
      bcnt_nxt  = '0;
    end else if (state_nxt != state || adv_fire) begin
      blink_nxt = 1'b1;
      bcnt_nxt  = '0;
    end else if (bcnt == BLINK_MAX) begin
      blink_nxt = ~blink;
      bcnt_nxt  = '0;
    end else begin
      bcnt_nxt = bcnt + BW'(1);
    end

    hrs_nxt      = adv_fire && (state == SET_HRS || state == ALM_HRS);
    min_nxt      = adv_fire && (state == SET_MIN || state == ALM_MIN);
    day_nxt      = adv_fire && (state == SET_DAY);
    month_nxt    = adv_fire && (state == SET_MONTH);
    date_nxt     = adv_fire && (state == SET_DATE);
    timeset_nxt  = (state_nxt >= SET_HRS) && (state_nxt <= SET_DATE);
    alarmset_nxt = (state_nxt == ALM_HRS) || (state_nxt == ALM_MIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_sync <= '0;
      adv_sync  <= '0;
      hold      <= '0;
      idle      <= '0;
      bcnt      <= '0;
      rep_en    <= 1'b0;
      blink     <= 1'b0;
      alarmon   <= 1'b0;
      timeset   <= 1'b0;
      alarmset  <= 1'b0;
      hrsadv    <= 1'b0;
      minadv    <= 1'b0;
      dayadv    <= 1'b0;
      dateadv   <= 1'b0;
      monthadv  <= 1'b0;
    end else begin
      mode_sync <= {mode_sync[1:0], mode_btn};
      adv_sync  <= {adv_sync[1:0], adv_btn};
      hold      <= hold_nxt;
      idle      <= idle_nxt;
      bcnt      <= bcnt_nxt;
      rep_en    <= rep_en_nxt;
      blink     <= blink_nxt;
      alarmon   <= alarmon_nxt;
      timeset   <= timeset_nxt;
      alarmset  <= alarmset_nxt;
      hrsadv    <= hrs_nxt;
      minadv    <= min_nxt;
      dayadv    <= day_nxt;
      dateadv   <= date_nxt;
      monthadv  <= month_nxt;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected output events with
// their cycle stamps, a negedge monitor pops and compares whenever outputs move.
module tb_clock_set_ctrl;
  logic       clk = 1'b0, rst = 1'b0, mode_btn = 1'b0, adv_btn = 1'b0;
  logic       timeset, alarmset, hrsadv, minadv, dayadv, dateadv, monthadv, alarmon, blink;
  logic [2:0] field;

  clock_set_ctrl dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .adv_btn(adv_btn),
    .timeset(timeset), .alarmset(alarmset), .hrsadv(hrsadv), .minadv(minadv),
    .dayadv(dayadv), .dateadv(dateadv), .monthadv(monthadv), .alarmon(alarmon),
    .field(field), .blink(blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;

  typedef struct {
    int         cyc;
    logic [2:0] field;
    logic       alarmon;
    logic [4:0] adv;   // {hrs, min, day, month, date}
  } exp_t;

  exp_t       q[$];
  logic [2:0] exp_field = 3'd0;
  logic       exp_alarmon = 1'b0;
  int         last_n = 0;

  function automatic void push(input int c, input logic [2:0] f, input logic a, input logic [4:0] v);
    exp_t e;
    e.cyc = c; e.field = f; e.alarmon = a; e.adv = v;
    q.push_back(e);
  endfunction

  function automatic logic [4:0] adv_for(input logic [2:0] f);
    case (f)
      3'd1, 3'd6: return 5'b10000;
      3'd2, 3'd7: return 5'b01000;
      3'd3:       return 5'b00100;
      3'd4:       return 5'b00010;
      3'd5:       return 5'b00001;
      default:    return 5'b00000;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int want);
    n_total++;
    if (act == want) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, want);
  endtask

  // Response to a press driven in cycle n is visible in cycle n+3.
  task automatic mode_tap(input logic with_adv);
    @(posedge clk); #1;
    last_n = cyc;
    mode_btn = 1'b1;
    adv_btn = with_adv;
    exp_field = exp_field + 3'd1;
    push(last_n + 3, exp_field, exp_alarmon, 5'b0);
    @(posedge clk); #1;
    mode_btn = 1'b0;
    adv_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic adv_tap();
    @(posedge clk); #1;
    last_n = cyc;
    adv_btn = 1'b1;
    if (exp_field == 3'd0) begin
      exp_alarmon = ~exp_alarmon;
      push(last_n + 3, 3'd0, exp_alarmon, 5'b0);
    end else begin
      push(last_n + 3, exp_field, exp_alarmon, adv_for(exp_field));
    end
    @(posedge clk); #1;
    adv_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sample_at(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  logic [2:0] prev_field = 3'd0;
  logic       prev_alarmon = 1'b0;

  always @(negedge clk) begin : monitor
    logic [4:0]  advv;
    logic [11:0] act, want;
    exp_t        e;
    advv = {hrsadv, minadv, dayadv, monthadv, dateadv};
    if (rst && (advv != 5'b0 || field != prev_field || alarmon != prev_alarmon)) begin
      act = {field, timeset, alarmset, alarmon, blink, advv};
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event cyc=%0d outputs=%b", cyc, act);
      end else begin
        e = q.pop_front();
        want = {e.field, (e.field >= 3'd1 && e.field <= 3'd5), (e.field >= 3'd6),
                e.alarmon, (e.field != 3'd0), e.adv};
        if (cyc == e.cyc && act == want) n_pass++;
        else $display("FAIL event cyc=%0d outputs=%b required cyc=%0d outputs=%b",
                      cyc, act, e.cyc, want);
      end
    end
    prev_field = field;
    prev_alarmon = alarmon;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish before timeout", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, e;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    sample_at(cyc + 20);
    check("idle_field", int'(field), 0);
    check("idle_timeset", int'(timeset), 0);
    check("idle_alarmset", int'(alarmset), 0);
    check("idle_alarmon", int'(alarmon), 0);
    check("idle_blink", int'(blink), 0);
    check("idle_adv", int'({hrsadv, minadv, dayadv, monthadv, dateadv}), 0);

    for (int i = 0; i < 8; i++) mode_tap(1'b0);

    mode_tap(1'b0);
    mode_tap(1'b0);
    e = last_n + 3;
    sample_at(e + 3);
    check("blink_first_half", int'(blink), 1);
    sample_at(e + 4);
    check("blink_toggle", int'(blink), 0);

    @(posedge clk); #1;
    n = cyc;
    adv_btn = 1'b1;
    push(n + 3,  3'd2, exp_alarmon, 5'b01000);
    push(n + 11, 3'd2, exp_alarmon, 5'b01000);
    push(n + 13, 3'd2, exp_alarmon, 5'b01000);
    push(n + 15, 3'd2, exp_alarmon, 5'b01000);
    push(n + 17, 3'd2, exp_alarmon, 5'b01000);
    repeat (15) @(posedge clk);
    #1 adv_btn = 1'b0;
    goto(n + 25);

    for (int i = 0; i < 6; i++) mode_tap(1'b0);

    adv_tap();
    adv_tap();

    for (int i = 0; i < 5; i++) mode_tap(1'b0);
    e = last_n + 3;
    goto(e + 56);
    adv_tap();
    push(e + 124, 3'd0, exp_alarmon, 5'b0);
    exp_field = 3'd0;
    goto(e + 130);
    check("timeout_timeset", int'(timeset), 0);

    mode_tap(1'b0);
    mode_tap(1'b1);

    @(posedge clk); #1;
    n = cyc;
    adv_btn = 1'b1;
    push(n + 3, 3'd2, exp_alarmon, 5'b01000);
    goto(n + 6);
    #1 rst = 1'b0;
    #1;
    check("rst_field", int'(field), 0);
    check("rst_adv", int'({hrsadv, minadv, dayadv, monthadv, dateadv}), 0);
    check("rst_timeset", int'(timeset), 0);
    check("rst_alarmset", int'(alarmset), 0);
    check("rst_blink", int'(blink), 0);
    check("rst_alarmon", int'(alarmon), 0);
    adv_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_field = 3'd0;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_field", int'(field), 0);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

User-interface sequencer for the lab clock/calendar datapath. It turns two raw push-buttons (MODE, ADV) into the mode levels and single-cycle advance enables that the time, calendar and alarm counters consume: `timeset`, `alarmset`, `minadv`, `hrsadv`, `dayadv`, `dateadv`, `monthadv` and `alarmon`. It adds synchronisation, edge detection, auto-repeat on a held ADV, an inactivity timeout back to run mode, and a blink strobe for the field being edited.

## Interface
- REPEAT_DELAY, default 8: cycles ADV must be held before the first auto-repeat pulse.
- REPEAT_RATE, default 2: cycles between auto-repeat pulses after the first.
- TIMEOUT, default 64: idle cycles in any set state before an automatic return to RUN.
- BLINK_HALF, default 4: half-period of `blink`, in cycles.

Ports:
- clk  in  1  Single clock; all state changes on its rising edge.
- rst  in  1  Asynchronous, active-low reset.
- mode_btn  in  1  Raw MODE button, asynchronous, active-high.
- adv_btn  in  1  Raw ADV button, asynchronous, active-high.
- timeset  out  1  High in SET_HRS, SET_MIN, SET_DAY, SET_MONTH and SET_DATE.
- alarmset  out  1  High in ALM_HRS and ALM_MIN.
- hrsadv, minadv, dayadv, dateadv, monthadv  out  1 each  Single-cycle advance pulses.
- alarmon  out  1  Alarm-enable level.
- field  out  3  Current state encoding.
- blink  out  1  Field-flash strobe; 0 in RUN.

## Operation
- Each button passes through a 2-flop synchroniser (s1, s2) and then a history flop (s3). A press event is `s2 & ~s3`.
- State encoding on `field`: RUN=0, SET_HRS=1, SET_MIN=2, SET_DAY=3, SET_MONTH=4, SET_DATE=5, ALM_HRS=6, ALM_MIN=7.
- A MODE press advances the state 0→1→…→7→0.
- An ADV press in RUN toggles `alarmon`. No advance pulse is issued.
- An ADV press in a set state emits one pulse on that field's advance output:
  - SET_HRS and ALM_HRS → `hrsadv`
  - SET_MIN and ALM_MIN → `minadv`
  - SET_DAY → `dayadv`
  - SET_MONTH → `monthadv`
  - SET_DATE → `dateadv`
- `hrsadv` and `minadv` are shared between time and alarm editing. The `alarmset` level selects which counter the datapath advances.
- Auto-repeat runs only in set states:
  - A hold counter clears on ADV release and counts while s2(ADV)=1.
  - When the count reaches REPEAT_DELAY, one pulse is emitted.
  - After that, one pulse every REPEAT_RATE cycles while ADV stays held.
- Inactivity timeout:
  - An idle counter clears on any press event and on entry to any state.
  - When it reaches TIMEOUT-1 in a set state, the next state is RUN.
  - The counter is held at 0 while in RUN.
- `blink` toggles every BLINK_HALF cycles in set states. Its phase restarts at 1 on every state entry and on every advance pulse.
- Simultaneous MODE and ADV press events in the same cycle: MODE wins. The ADV event is discarded and the hold counter clears.
- A MODE press while ADV is held: the state changes and the hold counter clears. Repeat restarts only after ADV is released and pressed again.
- At most one advance output is high in any cycle. All outputs are registered.

## Timing
- Reset (rst=0), asynchronous:
  - state=RUN, `alarmon`=0, every advance pulse 0, `blink`=0, `timeset`=0, `alarmset`=0, `field`=0.
  - Synchroniser and history flops = 0; all counters = 0.
- Reset asserted mid-edit aborts immediately. No pulse is emitted after rst falls.
- Press latency: a button sampled high at edge 0 gives s2=1 after edge 1. The registered response (pulse, state change, `alarmon` toggle) is visible after edge 2 and lasts exactly one cycle.
- `timeset`, `alarmset` and `field` change together, in the same cycle as the state change.
- Auto-repeat: with ADV continuously high, pulses appear at press+0, press+REPEAT_DELAY, then every +REPEAT_RATE cycles.
- The transition out of ALM_MIN (MODE press or timeout) lands on RUN with `alarmset`=0 in the same cycle.

## Test plan
- Reset then idle: 20 cycles with both buttons low → `field`=0, all outputs 0, `alarmon`=0.
- Seven MODE taps, each 1 cycle high and 5 apart → `field` steps 1..7. `timeset` is high for fields 1–5 and `alarmset` for fields 6–7. An eighth tap returns `field` to 0.
- In SET_MIN, hold ADV for 14 cycles with defaults → `minadv` pulses at relative cycles 0, 8, 10, 12, 14 (five pulses). No other advance output is ever high.
- In RUN, two ADV taps → `alarmon` goes 0→1→0, with zero advance pulses.
- Enter SET_DATE, then idle 64 cycles → back to RUN on cycle 64, `timeset`=0. An ADV tap at cycle 60 restarts the count.
- Raise MODE and ADV in the same cycle in SET_HRS → `field`=2, no `hrsadv`. Drop rst mid-repeat → all outputs 0 asynchronously, `field`=0.
